// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: register index, data word, and the memory-wait state.
package rv32i_types;

    typedef logic [4:0]  rv32i_reg;
    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        I_DONE = 2'd1,
        D_DONE = 2'd2
    } stall_state_t;

    localparam rv32i_word STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: the EX-stage load writes a register that the ID-stage instruction reads.
module hazard_detect
    import rv32i_types::*;
(
    input  rv32i_reg id_rs1,
    input  rv32i_reg id_rs2,
    input  rv32i_reg ex_rd,
    input  logic     ex_mem_read,
    output logic     load_use
);

    // x0 is never a real dependency
    assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline advance/stall control: waits for both memory responses, applies load-use and
// redirect bubbles, and counts the cycles in which the pipeline does not advance.
//
//   state  | meaning
//   RUN    | neither response captured this instruction window
//   I_DONE | imem satisfied, waiting on dmem
//   D_DONE | dmem satisfied, waiting on imem
module pipeline_stall_ctrl
    import rv32i_types::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      imem_resp,
    input  logic      dmem_resp,
    input  logic      mem_mem_read,
    input  logic      mem_mem_write,
    input  rv32i_reg  id_rs1,
    input  rv32i_reg  id_rs2,
    input  rv32i_reg  ex_rd,
    input  logic      ex_mem_read,
    input  logic      ex_br_redirect,
    output logic      imem_read,
    output logic      dmem_read,
    output logic      dmem_write,
    output logic      load_pc,
    output logic      load_if_id,
    output logic      load_id_ex,
    output logic      load_ex_mem,
    output logic      load_mem_wb,
    output logic      flush_if_id,
    output logic      flush_id_ex,
    output rv32i_word stall_cycles
);

    stall_state_t state_q, state_d;
    rv32i_word    stall_cnt_q, stall_cnt_d;
    logic         dreq, i_ok, d_ok, advance, adv_en, load_use, hold_front;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    always_comb begin
        dreq    = mem_mem_read | mem_mem_write;
        i_ok    = imem_resp | (state_q == I_DONE);
        d_ok    = ~dreq | dmem_resp | (state_q == D_DONE);
        advance = i_ok & d_ok;

        state_d = state_q;
        if (advance) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (imem_resp & ~d_ok) begin
                state_d = I_DONE;
            end else if (dreq & dmem_resp & ~imem_resp) begin
                state_d = D_DONE;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (!advance && stall_cnt_q != STALL_CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs are combinational for zero-latency advance; reset masks them immediately.
    assign adv_en     = advance & ~rst;
    assign hold_front = load_use & ~ex_br_redirect;

    assign imem_read    = ~rst & (state_q != I_DONE);
    assign dmem_read    = ~rst & mem_mem_read  & (state_q != D_DONE);
    assign dmem_write   = ~rst & mem_mem_write & (state_q != D_DONE);
    assign load_pc      = adv_en & ~hold_front;
    assign load_if_id   = adv_en & ~hold_front;
    assign load_id_ex   = adv_en;
    assign load_ex_mem  = adv_en;
    assign load_mem_wb  = adv_en;
    assign flush_if_id  = adv_en & ex_br_redirect;
    assign flush_id_ex  = adv_en & (ex_br_redirect | load_use);
    assign stall_cycles = stall_cnt_q;

endmodule
